// File: rtl/pipe_defs.sv
// Shared definitions for the pipeline control slice: hazard-controller
// state encodings, the hard-wired zero register and the bit layout of the
// ID/EX control vector that the bubble mux clears.
package pipe_defs;

    // Hazard controller states; the two spare codes decode back to RUN.
    typedef enum logic [1:0] {
        ST_RUN     = 2'b00,
        ST_MD_BUSY = 2'b01
    } hz_state_t;

    // $zero never carries a real dependency.
    localparam logic [4:0] REG_ZERO = 5'd0;

    // Control-vector bit positions consumed by the ID/EX bubble mux.
    localparam int CTL_MEMTOREG = 7;
    localparam int CTL_REGWRITE = 6;
    localparam int CTL_MEMREAD  = 5;
    localparam int CTL_MEMWRITE = 4;
    localparam int CTL_BRANCH   = 3;
    localparam int CTL_REGDST   = 2;
    localparam int CTL_ALUOP    = 1;
    localparam int CTL_ALUSRC   = 0;
    localparam int CTL_W        = 8;

endpackage

// File: rtl/md_timer.sv
// Loadable down-counter that times the multiply/divide unit's EX occupancy.
// A load sets the count to MD_CYCLES-1; done is high while the count is 0,
// which marks the last busy cycle.
module md_timer #(
    parameter int MD_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic dec,
    output logic done
);

    localparam int CW = $clog2(MD_CYCLES);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MD_CYCLES - 1);
    localparam logic [CW-1:0] ONE      = CW'(1);

    logic [CW-1:0] cnt_q;

    // Counter: load wins over decrement, and the count parks at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= LOAD_VAL;
        end else if (dec && (cnt_q != '0)) begin
            cnt_q <= cnt_q - ONE;
        end
    end

    // Done flag: count has run out.
    always_comb begin
        done = (cnt_q == '0);
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage single-issue MIPS pipeline.
// Detects load-use and HI/LO (multiply/divide) hazards on the instruction
// in ID, answers them in the same cycle by freezing PC and IF/ID and
// bubbling ID/EX, tracks the MD unit's busy window and counts bubble
// cycles for debug.
module hazard_ctrl
    import pipe_defs::*;
#(
    parameter int MD_CYCLES = 4,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_uses_rt,
    input  logic             id_is_md,
    input  logic             id_reads_hilo,
    input  logic             ex_memread,
    input  logic [4:0]       ex_rt,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             ctrl_sel,
    output logic             md_busy,
    output logic [CNT_W-1:0] stall_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Saturating increment: the debug counter sticks at all-ones.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : (v + CNT_ONE);
    endfunction

    hz_state_t state_q;
    hz_state_t state_d;

    logic rs_hit;
    logic rt_hit;
    logic lu;
    logic mh;
    logic stall;
    logic md_issue;
    logic md_done;

    // Hazard detection: load-use against EX, HI/LO use while MD is busy.
    always_comb begin
        rs_hit   = (ex_rt == id_rs);
        rt_hit   = id_uses_rt && (ex_rt == id_rt);
        lu       = ex_memread && (ex_rt != REG_ZERO) && (rs_hit || rt_hit);
        mh       = (state_q == ST_MD_BUSY) && (id_is_md || id_reads_hilo);
        stall    = lu || mh;
        // A stalled MULT/DIV is replayed, so it only issues on the cycle it
        // actually leaves ID; while MD is busy mh keeps it held.
        md_issue = (state_q == ST_RUN) && id_is_md && !stall && !rst;
    end

    md_timer #(
        .MD_CYCLES (MD_CYCLES)
    ) u_md_timer (
        .clk  (clk),
        .rst  (rst),
        .load (md_issue),
        .dec  (state_q == ST_MD_BUSY),
        .done (md_done)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: enter MD_BUSY on issue, leave when the timer runs out.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (md_issue) begin
                    state_d = ST_MD_BUSY;
                end
            end
            ST_MD_BUSY: begin
                if (md_done) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // Outputs: everything is held inactive during reset; otherwise the stall
    // freezes fetch and bubbles ID/EX, and it also suppresses a taken-branch
    // flush so the branch resolves again once the stall clears.
    always_comb begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        ctrl_sel   = 1'b0;
        ifid_flush = 1'b0;
        md_busy    = 1'b0;
        if (!rst) begin
            pc_write   = !stall;
            ifid_write = !stall;
            ctrl_sel   = !stall;
            ifid_flush = branch_taken && !stall;
            md_busy    = (state_q == ST_MD_BUSY);
        end
    end

    // Bubble-cycle counter: one count per stalled edge, however many
    // hazards caused it.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (stall) begin
            stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a default instance (MD_CYCLES=4, CNT_W=16)
// plus a CNT_W=2 instance sharing the same stimulus for counter saturation.
`define CHK(tag, obs, exp) check(tag, 32'(obs), 32'(exp))

module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs;
    logic [4:0]  id_rt;
    logic        id_uses_rt;
    logic        id_is_md;
    logic        id_reads_hilo;
    logic        ex_memread;
    logic [4:0]  ex_rt;
    logic        branch_taken;

    logic        pc_write, ifid_write, ifid_flush, ctrl_sel, md_busy;
    logic [15:0] stall_cnt;
    logic        pc_write2, ifid_write2, ifid_flush2, ctrl_sel2, md_busy2;
    logic [1:0]  stall_cnt2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(.MD_CYCLES(4), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_md(id_is_md),
        .id_reads_hilo(id_reads_hilo), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .branch_taken(branch_taken),
        .pc_write(pc_write), .ifid_write(ifid_write),
        .ifid_flush(ifid_flush), .ctrl_sel(ctrl_sel),
        .md_busy(md_busy), .stall_cnt(stall_cnt)
    );

    hazard_ctrl #(.MD_CYCLES(4), .CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rt(id_uses_rt), .id_is_md(id_is_md),
        .id_reads_hilo(id_reads_hilo), .ex_memread(ex_memread),
        .ex_rt(ex_rt), .branch_taken(branch_taken),
        .pc_write(pc_write2), .ifid_write(ifid_write2),
        .ifid_flush(ifid_flush2), .ctrl_sel(ctrl_sel2),
        .md_busy(md_busy2), .stall_cnt(stall_cnt2)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; id_is_md = 1'b0;
        id_reads_hilo = 1'b0; ex_memread = 1'b0; ex_rt = 5'd0; branch_taken = 1'b0;
    endtask

    task automatic to_mid();
        @(negedge clk);
    endtask

    task automatic to_next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset with a hazard, an MD op and a branch present.
        rst = 1'b1; idle();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; id_is_md = 1'b1; branch_taken = 1'b1;
        to_mid();
        `CHK("rst_pc_write", pc_write, 0);
        `CHK("rst_ifid_write", ifid_write, 0);
        `CHK("rst_ctrl_sel", ctrl_sel, 0);
        `CHK("rst_ifid_flush", ifid_flush, 0);
        `CHK("rst_md_busy", md_busy, 0);
        to_next(); to_mid();
        `CHK("rst_stall_cnt", stall_cnt, 0);
        to_next();
        rst = 1'b0; idle();
        to_mid();
        `CHK("run_pc_write", pc_write, 1);
        `CHK("run_ifid_write", ifid_write, 1);
        `CHK("run_ctrl_sel", ctrl_sel, 1);
        `CHK("run_flush", ifid_flush, 0);
        `CHK("run_md_busy", md_busy, 0);
        `CHK("run_stall_cnt", stall_cnt, 0);

        // LW $t1 in EX, ADD reading $t1 in ID.
        to_next();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        to_mid();
        `CHK("lu_pc_write", pc_write, 0);
        `CHK("lu_ifid_write", ifid_write, 0);
        `CHK("lu_ctrl_sel", ctrl_sel, 0);
        `CHK("lu_cnt_before", stall_cnt, 0);
        to_next(); idle();
        to_mid();
        `CHK("lu_released", pc_write, 1);
        `CHK("lu_cnt_after", stall_cnt, 1);
        `CHK("lu_cnt_sat_inst", stall_cnt2, 1);

        // Loads to $zero and unused rt are not hazards; used rt is.
        to_next();
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        to_mid();
        `CHK("zero_reg_no_stall", ctrl_sel, 1);
        to_next();
        ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd9; id_uses_rt = 1'b0;
        to_mid();
        `CHK("rt_unused_no_stall", ctrl_sel, 1);
        to_next();
        id_uses_rt = 1'b1;
        to_mid();
        `CHK("rt_used_stall", ctrl_sel, 0);
        to_next(); idle();
        to_mid();
        `CHK("rt_cnt", stall_cnt, 2);

        // MULT then MFLO: held for the whole 4-cycle window.
        to_next();
        id_is_md = 1'b1;
        to_mid();
        `CHK("mult_issue_ctrl", ctrl_sel, 1);
        `CHK("mult_issue_busy", md_busy, 0);
        to_next(); idle(); id_reads_hilo = 1'b1;
        for (int i = 0; i < 4; i++) begin
            to_mid();
            tests++;
            if (md_busy !== 1'b1) begin
                fails++;
                $error("FAIL mflo_busy: observed %0h expected 1", md_busy);
            end
            tests++;
            if (ctrl_sel !== 1'b0) begin
                fails++;
                $error("FAIL mflo_held: observed %0h expected 0", ctrl_sel);
            end
            to_next();
        end
        to_mid();
        `CHK("mflo_busy_drop", md_busy, 0);
        `CHK("mflo_proceeds", ctrl_sel, 1);
        `CHK("mflo_cnt", stall_cnt, 6);
        `CHK("mflo_cnt_sat", stall_cnt2, 3);
        to_next(); idle();

        // MULT followed by independent ADD, LW and taken BEQ.
        id_is_md = 1'b1;
        to_mid();
        `CHK("mult2_issue", ctrl_sel, 1);
        to_next(); idle();
        to_mid();
        `CHK("indep_add_busy", md_busy, 1);
        `CHK("indep_add_ctrl", ctrl_sel, 1);
        to_next();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd3; id_rt = 5'd4; id_uses_rt = 1'b1;
        to_mid();
        `CHK("indep_lw_ctrl", ctrl_sel, 1);
        to_next(); idle(); branch_taken = 1'b1;
        to_mid();
        `CHK("indep_beq_flush", ifid_flush, 1);
        `CHK("indep_beq_ctrl", ctrl_sel, 1);
        `CHK("indep_beq_busy", md_busy, 1);
        to_next(); idle();
        to_mid();
        `CHK("flush_one_cycle", ifid_flush, 0);
        `CHK("busy_last_cycle", md_busy, 1);
        to_next();
        to_mid();
        `CHK("busy_window_end", md_busy, 0);
        `CHK("indep_cnt", stall_cnt, 6);

        // Taken branch during load-use: stall wins, branch flushes later.
        to_next();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9; branch_taken = 1'b1;
        to_mid();
        `CHK("br_lu_flush", ifid_flush, 0);
        `CHK("br_lu_stall", pc_write, 0);
        to_next(); idle(); branch_taken = 1'b1;
        to_mid();
        `CHK("br_after_flush", ifid_flush, 1);
        `CHK("br_after_pc", pc_write, 1);
        `CHK("br_cnt", stall_cnt, 7);
        to_next(); idle();

        // MD issue blocked by load-use, then lu and mh together.
        id_is_md = 1'b1; ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        to_mid();
        `CHK("md_blocked_ctrl", ctrl_sel, 0);
        to_next();
        ex_memread = 1'b0;
        to_mid();
        `CHK("md_blocked_no_busy", md_busy, 0);
        `CHK("md_late_issue", ctrl_sel, 1);
        `CHK("md_blocked_cnt", stall_cnt, 8);
        to_next(); idle();
        id_reads_hilo = 1'b1; ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        to_mid();
        `CHK("lu_mh_busy", md_busy, 1);
        `CHK("lu_mh_ctrl", ctrl_sel, 0);
        to_next();
        ex_memread = 1'b0;
        for (int i = 0; i < 3; i++) begin
            to_mid();
            tests++;
            if (md_busy !== 1'b1) begin
                fails++;
                $error("FAIL lu_mh_busy_hold: observed %0h expected 1", md_busy);
            end
            to_next();
        end
        to_mid();
        `CHK("lu_mh_done", md_busy, 0);
        `CHK("lu_mh_cnt", stall_cnt, 12);
        to_next(); idle();
        to_mid();
        `CHK("no_double_issue", md_busy, 0);

        // Reset in the middle of an MD window (timer at 2).
        to_next();
        id_is_md = 1'b1;
        to_next(); idle();
        to_mid();
        `CHK("pre_rst_busy", md_busy, 1);
        to_next();
        rst = 1'b1;
        to_mid();
        `CHK("mid_rst_busy", md_busy, 0);
        `CHK("mid_rst_pc", pc_write, 0);
        to_next();
        rst = 1'b0;
        to_mid();
        `CHK("post_rst_busy", md_busy, 0);
        `CHK("post_rst_cnt", stall_cnt, 0);
        `CHK("post_rst_cnt_sat", stall_cnt2, 0);
        `CHK("post_rst_ctrl", ctrl_sel, 1);
        to_next();
        to_mid();
        `CHK("no_busy_pulse", md_busy, 0);

        // Five stalled cycles: 16-bit counter reads 5, 2-bit counter sticks at 3.
        to_next();
        ex_memread = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
        repeat (5) to_next();
        idle();
        to_mid();
        `CHK("sat_wide_cnt", stall_cnt, 5);
        `CHK("sat_narrow_cnt", stall_cnt2, 3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`undef CHK

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard controller for the 5-stage single-issue MIPS core.
- Detects load-use and multiply/divide (HI/LO) hazards in ID and sequences stalls.
- Drives the select of the ID/EX control-bubble mux (1 = pass decoded control, 0 = zero all control bits), PC write enable and IF/ID write/flush.
- Tracks the multi-cycle MD unit's busy window with an internal down-counter and keeps a saturating stall-cycle counter for debug.

Parameters:
- MD_CYCLES, 4, EX occupancy of a MULT/DIV in cycles; legal range 2..16.
- CNT_W, 16, width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous reset, active-high
- id_rs  in  5  rs field of the instruction in ID
- id_rt  in  5  rt field of the instruction in ID
- id_uses_rt  in  1  ID instruction reads rt as a source
- id_is_md  in  1  ID instruction is MULT/MULTU/DIV/DIVU
- id_reads_hilo  in  1  ID instruction is MFHI/MFLO
- ex_memread  in  1  EX-stage instruction is a load
- ex_rt  in  5  destination rt of the EX-stage instruction
- branch_taken  in  1  branch/jump resolved taken in ID this cycle
- pc_write  out  1  PC register write enable
- ifid_write  out  1  IF/ID register write enable
- ifid_flush  out  1  clear IF/ID to NOP on next edge
- ctrl_sel  out  1  bubble-mux select; 0 inserts a bubble into ID/EX
- md_busy  out  1  MD unit occupied
- stall_cnt  out  CNT_W  saturating count of bubble cycles

Behaviour:
- Reset: while rst=1, and on the edge it is sampled:
  - state <= RUN, md counter <= 0, stall_cnt <= 0.
  - Combinational outputs are forced to pc_write=0, ifid_write=0, ctrl_sel=0, ifid_flush=0, md_busy=0.
  - Reset during MD_BUSY aborts the window; no md_busy pulse follows.
- States: RUN, MD_BUSY (2-bit encoding; spare code returns to RUN).
- Load-use hazard `lu`, combinational:
  - lu = ex_memread & (ex_rt != 0) & ((ex_rt == id_rs) | (id_uses_rt & ex_rt == id_rt)).
- MD hazard `mh`, combinational: mh = (state == MD_BUSY) & (id_is_md | id_reads_hilo).
- Stall: stall = lu | mh. Same-cycle (zero-latency) response:
  - pc_write = ~stall
  - ifid_write = ~stall
  - ctrl_sel = ~stall
- Flush: ifid_flush = branch_taken & ~stall.
  - A stall takes precedence over a taken branch; the branch re-resolves once the stall clears.
- MD issue, RUN -> MD_BUSY: occurs when id_is_md & ~stall.
  - Counter loads MD_CYCLES-1.
  - md_busy = 1 from the next cycle, for exactly MD_CYCLES cycles.
- MD_BUSY:
  - Counter decrements each cycle.
  - When the counter == 0, go to RUN on the next edge; md_busy drops that edge.
  - Independent instructions, including loads and branches, proceed unstalled.
- Simultaneous lu and mh: a single stall; stall_cnt increments once.
- MD issue blocked by lu: no issue that cycle; issue happens on the first unstalled cycle.
- A stall lasting N cycles repeats the same ID instruction; it never double-issues an MD op.
- stall_cnt increments on every edge with stall=1 and rst=0; it saturates at all-ones, with no wrap.
- All state is registered on posedge clk; outputs other than md_busy and stall_cnt are combinational.

Decomposition:
- Shared package/header `pipe_defs`:
  - state encodings (RUN, MD_BUSY)
  - REG_ZERO = 5'd0
  - the control-vector bit positions already used by the bubble mux (MemtoReg 7 ... ALUSrc 0)
- One natural sub-module: `md_timer`, the loadable down-counter with a done flag, parameterised by MD_CYCLES.
- Hazard compare logic stays inline.

Test Plan:
- LW $t1 in EX (ex_memread=1, ex_rt=9), ADD reading rs=9 in ID -> exactly 1 cycle with pc_write=ifid_write=ctrl_sel=0; stall_cnt 0->1.
- Load to $zero (ex_rt=0, id_rs=0) -> no stall, ctrl_sel=1; also id_rt=9 with id_uses_rt=0 and ex_rt=9 -> no stall.
- MULT issues with MD_CYCLES=4, MFLO arrives next cycle -> md_busy=1 for 4 cycles; MFLO held 4 cycles with ctrl_sel=0; stall_cnt=4; MFLO proceeds on the cycle md_busy drops.
- MULT followed by independent ADD, LW and taken BEQ -> no stall during MD_BUSY; ifid_flush=1 for one cycle on the branch.
- branch_taken=1 in the same cycle as a load-use hazard -> ifid_flush=0, stall=1; next cycle (hazard gone) ifid_flush=1.
- rst=1 for one cycle in mid MD_BUSY (counter=2) -> next cycle state RUN, md_busy=0, stall_cnt=0; with CNT_W=2 and 5 stall cycles, stall_cnt saturates at 3.
